// File: rtl/neuro_mem_arbiter_pkg.sv
// rtl/neuro_mem_arbiter_pkg.sv - shared types and constants for the neuron memory arbiter
package neuro_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;
   localparam int RUN_CNT_W  = 16;

   localparam logic [7:0] END_OF_PROGRAM = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_DRAIN = 2'b10,
      ST_DONE  = 2'b11
   } arb_state_t;

   function automatic logic [RUN_CNT_W-1:0] sat_inc(input logic [RUN_CNT_W-1:0] v);
      return (v == {RUN_CNT_W{1'b1}}) ? v : v + RUN_CNT_W'(1);
   endfunction

endpackage

// File: rtl/neuro_mem_arbiter_if.sv
// rtl/neuro_mem_arbiter_if.sv - host request/ack bus into the neuron memory arbiter
interface neuro_mem_arbiter_if
   import neuro_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);

   logic              host_req;
   logic              host_we;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic              host_ack;
   logic [DATA_W-1:0] host_rdata;
   logic              host_busy;

   modport master (
      output host_req, host_we, host_addr, host_wdata,
      input  host_ack, host_rdata, host_busy
   );

   modport slave (
      input  host_req, host_we, host_addr, host_wdata,
      output host_ack, host_rdata, host_busy
   );

endinterface

// File: rtl/neuro_arb_drain_cnt.sv
// rtl/neuro_arb_drain_cnt.sv - loadable down-counter timing DRAIN and the RUN watchdog
module neuro_arb_drain_cnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/neuro_mem_arbiter.sv
// rtl/neuro_mem_arbiter.sv - host/accelerator ownership arbiter for the neuron RAM
// Optional RUN watchdog enabled by defining NEURO_ARB_WATCHDOG_EN.
module neuro_mem_arbiter
   import neuro_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int DRAIN_CYCLES = 2,
   parameter int WDOG_CYCLES  = 4096
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   neuro_mem_arbiter_if.slave   host,
   input  logic [ADDR_W-1:0]    acc_rd_addr,
   input  logic [ADDR_W-1:0]    acc_wr_addr,
   input  logic [DATA_W-1:0]    acc_wr_data,
   input  logic                 acc_we,
   input  logic                 acc_finished,
   input  logic [ADDR_W-1:0]    acc_result_base,
   input  logic [7:0]           acc_result_count,
   output logic                 acc_reset,
   output logic [ADDR_W-1:0]    mem_rd_addr,
   output logic [ADDR_W-1:0]    mem_wr_addr,
   output logic [DATA_W-1:0]    mem_wr_data,
   output logic                 mem_we,
   input  logic [DATA_W-1:0]    mem_rd_data,
   output logic                 done,
   output logic                 error,
   output logic [ADDR_W-1:0]    result_base,
   output logic [7:0]           result_count,
   output logic [RUN_CNT_W-1:0] run_cycles
);

   // One counter serves both DRAIN and the watchdog, so size it for the larger load.
   localparam int CNT_MAX = (WDOG_CYCLES > DRAIN_CYCLES) ? WDOG_CYCLES : DRAIN_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

   arb_state_t        state, state_n;
   logic              host_owns;
   logic              host_accept;
   logic              cnt_load;
   logic [CNT_W-1:0]  cnt_load_val;
   logic              cnt_dec;
   logic              cnt_zero;
   logic              finish_take;
   logic              enter_done;
   logic              ack_q;
   logic [DATA_W-1:0] rdata_q;

`ifdef NEURO_ARB_WATCHDOG_EN
   localparam logic [CNT_W-1:0] WDOG_LOAD = CNT_W'(WDOG_CYCLES - 1);
   logic wdog_trip;
   logic error_q;
`endif

   assign host_owns   = (state == ST_IDLE) || (state == ST_DONE);
   assign host_accept = host_owns & host.host_req & ~start & ~reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n      = state;
      cnt_load     = 1'b0;
      cnt_load_val = DRAIN_LOAD;
      cnt_dec      = 1'b0;
      finish_take  = 1'b0;
      enter_done   = 1'b0;
`ifdef NEURO_ARB_WATCHDOG_EN
      wdog_trip    = 1'b0;
`endif
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_n = ST_RUN;
`ifdef NEURO_ARB_WATCHDOG_EN
               cnt_load     = 1'b1;
               cnt_load_val = WDOG_LOAD;
`endif
            end
         end
         ST_RUN: begin
            if (acc_finished) begin
               state_n      = ST_DRAIN;
               finish_take  = 1'b1;
               cnt_load     = 1'b1;
               cnt_load_val = DRAIN_LOAD;
            end
`ifdef NEURO_ARB_WATCHDOG_EN
            else begin
               cnt_dec = 1'b1;
               if (cnt_zero) begin
                  state_n    = ST_DONE;
                  enter_done = 1'b1;
                  wdog_trip  = 1'b1;
               end
            end
`endif
         end
         ST_DRAIN: begin
            if (cnt_zero) begin
               state_n    = ST_DONE;
               enter_done = 1'b1;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   neuro_arb_drain_cnt #(.W(CNT_W)) u_drain_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         ack_q        <= 1'b0;
         rdata_q      <= '0;
         done         <= 1'b0;
         result_base  <= '0;
         result_count <= '0;
         run_cycles   <= '0;
      end else begin
         ack_q <= host_accept;
         if (host_accept && !host.host_we) begin
            rdata_q <= mem_rd_data;
         end
         if (host_owns && start) begin
            done       <= 1'b0;
            run_cycles <= '0;
         end else if (!host_owns) begin
            run_cycles <= sat_inc(run_cycles);
         end
         if (finish_take) begin
            result_base  <= acc_result_base;
            result_count <= acc_result_count;
         end
         if (enter_done) begin
            done <= 1'b1;
         end
`ifdef NEURO_ARB_WATCHDOG_EN
         if (wdog_trip) begin
            result_count <= '0;
         end
`endif
      end
   end

`ifdef NEURO_ARB_WATCHDOG_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         error_q <= 1'b0;
      end else if (host_owns && start) begin
         error_q <= 1'b0;
      end else if (wdog_trip) begin
         error_q <= 1'b1;
      end
   end
   assign error = error_q;
`else
   assign error = 1'b0;
`endif

   // Host writes only land when the access is actually granted.
   assign mem_rd_addr = host_owns ? host.host_addr  : acc_rd_addr;
   assign mem_wr_addr = host_owns ? host.host_addr  : acc_wr_addr;
   assign mem_wr_data = host_owns ? host.host_wdata : acc_wr_data;
   assign mem_we      = host_owns ? (host_accept & host.host_we) : acc_we;
   assign acc_reset   = host_owns;

   assign host.host_ack   = ack_q;
   assign host.host_rdata = rdata_q;
   assign host.host_busy  = ~host_owns;

endmodule

// File: tb/tb_neuro_mem_arbiter.sv
// tb/tb_neuro_mem_arbiter.sv - self-checking bench for neuro_mem_arbiter
module tb_neuro_mem_arbiter;

   localparam int AW    = 8;
   localparam int DW    = 8;
   localparam int DRAIN = 2;
   localparam int WDOG  = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] acc_rd_addr, acc_wr_addr, acc_result_base;
   logic [DW-1:0] acc_wr_data;
   logic          acc_we, acc_finished;
   logic [7:0]    acc_result_count;
   logic          acc_reset;
   logic [AW-1:0] mem_rd_addr, mem_wr_addr;
   logic [DW-1:0] mem_wr_data, mem_rd_data;
   logic          mem_we;
   logic          done, error;
   logic [AW-1:0] result_base;
   logic [7:0]    result_count;
   logic [15:0]   run_cycles;

   neuro_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   neuro_mem_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .DRAIN_CYCLES(DRAIN), .WDOG_CYCLES(WDOG)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .host             (bus),
      .acc_rd_addr      (acc_rd_addr),
      .acc_wr_addr      (acc_wr_addr),
      .acc_wr_data      (acc_wr_data),
      .acc_we           (acc_we),
      .acc_finished     (acc_finished),
      .acc_result_base  (acc_result_base),
      .acc_result_count (acc_result_count),
      .acc_reset        (acc_reset),
      .mem_rd_addr      (mem_rd_addr),
      .mem_wr_addr      (mem_wr_addr),
      .mem_wr_data      (mem_wr_data),
      .mem_we           (mem_we),
      .mem_rd_data      (mem_rd_data),
      .done             (done),
      .error            (error),
      .result_base      (result_base),
      .result_count     (result_count),
      .run_cycles       (run_cycles)
   );

   always #5 clk = ~clk;

   // Environment RAM driven only by the DUT; model_mem is what the spec says it should hold.
   logic [DW-1:0] ram [0:255];
   logic [DW-1:0] model_mem [0:255];
   assign mem_rd_data = ram[mem_rd_addr];

   always @(posedge clk) begin
      if (reset && start) begin
         for (int i = 0; i < 256; i++) ram[i] <= '0;
      end else if (mem_we) begin
         ram[mem_wr_addr] <= mem_wr_data;
      end
   end

   int          checks = 0;
   int          errors = 0;
   logic        m_busy;
   logic [15:0] m_cycles;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (m_busy && m_cycles != 16'hFFFF) m_cycles++;
      #1;
   endtask

   task automatic host_op(input logic we, input logic [7:0] a, input logic [7:0] d);
      bus.host_req   = 1'b1;
      bus.host_we    = we;
      bus.host_addr  = a;
      bus.host_wdata = d;
      if (we) model_mem[a] = d;
      tick();
      bus.host_req = 1'b0;
      check("host_ack_n1", bus.host_ack, 1);
      if (!we) check("host_rdata", bus.host_rdata, model_mem[a]);
      tick();
      check("host_ack_pulse", bus.host_ack, 0);
   endtask

   task automatic acc_drive(input logic we, input logic [7:0] a, input logic [7:0] d);
      acc_we      = we;
      acc_wr_addr = a;
      acc_wr_data = d;
      acc_rd_addr = 8'($urandom);
      if (we) model_mem[a] = d;
      #1;
      check("fwd_we", mem_we, we);
      check("fwd_waddr", mem_wr_addr, a);
      check("fwd_wdata", mem_wr_data, d);
      check("fwd_raddr", mem_rd_addr, acc_rd_addr);
      check("busy_run", bus.host_busy, 1);
   endtask

   task automatic mem_compare(input string tag);
      int bad;
      bad = 0;
      for (int i = 0; i < 256; i++) if (ram[i] !== model_mem[i]) bad++;
      check(tag, bad, 0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b1;
      acc_rd_addr = '0; acc_wr_addr = '0; acc_wr_data = '0; acc_we = 1'b0;
      acc_finished = 1'b0; acc_result_base = '0; acc_result_count = '0;
      bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
      m_busy = 1'b0; m_cycles = '0;
      for (int i = 0; i < 256; i++) model_mem[i] = '0;
      tick();
      start = 1'b0;
      tick();
      check("rst_ack", bus.host_ack, 0);
      check("rst_rdata", bus.host_rdata, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_result", {result_base, result_count}, 0);
      check("rst_run_cycles", run_cycles, 0);
      check("rst_acc_reset", acc_reset, 1);
      check("rst_busy", bus.host_busy, 0);
      reset = 1'b0;
      tick();

      // Basic write/readback.
      host_op(1'b1, 8'h05, 8'h11);
      host_op(1'b0, 8'h05, 8'h00);
      check("readback_11", bus.host_rdata, 8'h11);

      for (int i = 0; i < 16; i++) host_op(1'($urandom), 8'($urandom), 8'($urandom));
      mem_compare("mem_after_host");

      // start wins over a same-cycle host write, which is then held through the run.
      start = 1'b1;
      bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 8'h20; bus.host_wdata = 8'hAA;
      tick();
      start = 1'b0;
      m_busy = 1'b1; m_cycles = '0;
      check("start_no_ack", bus.host_ack, 0);
      check("start_busy", bus.host_busy, 1);
      check("start_acc_reset", acc_reset, 0);
      check("start_run_cycles", run_cycles, 0);

      acc_drive(1'b1, 8'h14, 8'h3C);
      tick();
      check("run_no_ack", bus.host_ack, 0);
      for (int i = 0; i < 9; i++) begin
         start = (i == 3);
         acc_drive(1'($urandom), 8'($urandom_range(8'h40, 8'hFF)), 8'($urandom));
         tick();
         check("run_no_ack", bus.host_ack, 0);
      end
      start = 1'b0;
      check("run_cycles_run", run_cycles, 32'(m_cycles));

      // Finish, then exactly DRAIN cycles with writes still forwarded.
      acc_we = 1'b0;
      acc_finished = 1'b1; acc_result_base = 8'h14; acc_result_count = 8'd3;
      tick();
      acc_finished = 1'b1; acc_result_base = 8'h99; acc_result_count = 8'd7;
      for (int i = 0; i < DRAIN; i++) begin
         check("drain_done_low", done, 0);
         acc_drive(1'b1, 8'($urandom_range(8'h40, 8'hFF)), 8'($urandom));
         tick();
      end
      m_busy = 1'b0;
      acc_finished = 1'b0; acc_we = 1'b0;
      check("done_set", done, 1);
      check("done_error", error, 0);
      check("done_base", result_base, 8'h14);
      check("done_count", result_count, 8'd3);
      check("done_busy", bus.host_busy, 0);
      check("done_no_ack_yet", bus.host_ack, 0);
      check("done_run_cycles", run_cycles, 32'(m_cycles));
      model_mem[8'h20] = 8'hAA;
      tick();
      bus.host_req = 1'b0;
      check("held_ack", bus.host_ack, 1);
      acc_finished = 1'b1; acc_result_base = 8'h77;
      tick();
      acc_finished = 1'b0;
      check("held_ack_pulse", bus.host_ack, 0);
      tick();
      check("done_finish_ignored", result_base, 8'h14);
      check("done_held", done, 1);
      host_op(1'b0, 8'h14, 8'h00);
      mem_compare("mem_after_run");

      // Reset in the second DRAIN cycle.
      start = 1'b1;
      tick();
      start = 1'b0;
      m_busy = 1'b1; m_cycles = '0;
      check("restart_done_clr", done, 0);
      for (int i = 0; i < 3; i++) begin
         acc_drive(1'($urandom), 8'($urandom_range(8'h40, 8'hFF)), 8'($urandom));
         tick();
      end
      acc_we = 1'b0;
      acc_finished = 1'b1; acc_result_base = 8'h30; acc_result_count = 8'd5;
      tick();
      acc_finished = 1'b0;
      tick();
      reset = 1'b1;
      acc_drive(1'b1, 8'h30, 8'h5A);
      tick();
      m_busy = 1'b0; m_cycles = '0;
      check("rst_drain_busy", bus.host_busy, 0);
      check("rst_drain_done", done, 0);
      check("rst_drain_acc_reset", acc_reset, 1);
      check("rst_drain_mem_we", mem_we, 0);
      check("rst_drain_result", {result_base, result_count}, 0);
      check("rst_drain_run_cycles", run_cycles, 0);
      acc_we = 1'b0;
      bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 8'h05; bus.host_wdata = 8'hEE;
      tick();
      reset = 1'b0;
      bus.host_req = 1'b0;
      check("rst_no_ack", bus.host_ack, 0);
      tick();
      mem_compare("mem_after_reset");

      // Long RUN without acc_finished.
      start = 1'b1;
      tick();
      start = 1'b0;
      m_busy = 1'b1; m_cycles = '0;
`ifdef NEURO_ARB_WATCHDOG_EN
      for (int i = 0; i < WDOG; i++) tick();
      m_busy = 1'b0;
      check("wdog_done", done, 1);
      check("wdog_error", error, 1);
      check("wdog_count", result_count, 0);
      check("wdog_busy", bus.host_busy, 0);
      check("wdog_run_cycles", run_cycles, WDOG);
`else
      for (int i = 0; i < 40; i++) tick();
      check("nowdog_busy", bus.host_busy, 1);
      check("nowdog_done", done, 0);
      check("nowdog_error", error, 0);
      check("nowdog_run_cycles", run_cycles, 40);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
